// File: rtl/alu_arbiter.sv
// alu_arbiter: arbitrates two requesters onto one shared combinational ALU.
// Each accepted request runs IDLE -> EXEC -> RESP. The operands are driven to
// the ALU in EXEC. The result is registered at the end of EXEC and presented
// in RESP until the consumer accepts it.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   reqN_valid/a/b/op   - requester N operation (N = 0, 1)
//   reqN_ready          - accept strobe, combinational, IDLE only
//   alu_a/alu_b/alu_op  - operands and opcode to the shared ALU (registered)
//   alu_z/alu_zero      - combinational ALU result
//   resp_*              - response channel; resp_ready is the consumer accept
module alu_arbiter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_op,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         req1_ready,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_z,
  input  logic         alu_zero,
  output logic         resp_valid,
  output logic         resp_id,
  output logic [W-1:0] resp_z,
  output logic         resp_zero,
  output logic         resp_err,
  input  logic         resp_ready
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e       state_q, state_d;
  logic         rr_q;
  logic         grant_id_q;
  logic         grant_id;
  logic [W-1:0] a_q, b_q;
  logic [2:0]   op_q;
  logic         resp_id_q;
  logic [W-1:0] resp_z_q;
  logic         resp_zero_q;
  logic         resp_err_q;
  logic         op_legal;

  always_comb begin
    op_legal = 1'b0;
    unique case (op_q)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  end

  // Ready is only ever raised in IDLE. The if/else chain keeps it one-hot.
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant_id   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!reset) begin
          if (req0_valid && (!req1_valid || !rr_q)) begin
            req0_ready = 1'b1;
            grant_id   = 1'b0;
            state_d    = StExec;
          end else if (req1_valid) begin
            req1_ready = 1'b1;
            grant_id   = 1'b1;
            state_d    = StExec;
          end
        end
      end
      StExec: state_d = StResp;
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_q        <= 1'b0;
      grant_id_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      resp_id_q   <= 1'b0;
      resp_z_q    <= '0;
      resp_zero_q <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // Operands are sampled only on the grant cycle. They then hold until the
      // next grant, so the ALU inputs never toggle outside EXEC.
      if (req0_ready || req1_ready) begin
        grant_id_q <= grant_id;
        a_q        <= grant_id ? req1_a  : req0_a;
        b_q        <= grant_id ? req1_b  : req0_b;
        op_q       <= grant_id ? req1_op : req0_op;
      end
      if (state_q == StExec) begin
        resp_id_q   <= grant_id_q;
        resp_z_q    <= op_legal ? alu_z    : '0;
        resp_zero_q <= op_legal ? alu_zero : 1'b1;
        resp_err_q  <= !op_legal;
      end
      // Favour the other requester once this response is consumed.
      if (state_q == StResp && resp_ready) begin
        rr_q <= ~resp_id_q;
      end
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign resp_valid = (state_q == StResp);
  assign resp_id    = resp_id_q;
  assign resp_z     = resp_z_q;
  assign resp_zero  = resp_zero_q;
  assign resp_err   = resp_err_q;

endmodule
